// File: rtl/seq_divider_16.sv
// Iterative restoring divider: one trial subtraction per clock, signed or unsigned.
// Start/Busy/Done handshake; results are held until the next accepted operation finishes.
module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic             V,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH:0]   p_r;
  logic [CW-1:0]    cnt_r;
  logic             qneg_r;
  logic             rneg_r;
  logic             dz_r;
  logic             ov_r;

  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH:0]   p_next_s;
  logic             q_bit_s;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg(v) : v;
  endfunction

  // Trial subtraction of the divisor magnitude from the shifted partial remainder.
  always_comb begin
    p_shift_s = {p_r[WIDTH-1:0], dvd_r[WIDTH-1]};
    p_next_s  = p_shift_s;
    q_bit_s   = 1'b0;
    if (p_shift_s >= {1'b0, dvs_r}) begin
      p_next_s = p_shift_s - {1'b0, dvs_r};
      q_bit_s  = 1'b1;
    end else begin
      p_next_s = p_shift_s;
      q_bit_s  = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      dvd_r   <= ZERO;
      dvs_r   <= ZERO;
      quot_r  <= ZERO;
      a_r     <= ZERO;
      p_r     <= {(WIDTH+1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      qneg_r  <= 1'b0;
      rneg_r  <= 1'b0;
      dz_r    <= 1'b0;
      ov_r    <= 1'b0;
      Q       <= ZERO;
      R       <= ZERO;
      DZ      <= 1'b0;
      V       <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_r     <= A;
            dvd_r   <= mag(A, Signed);
            dvs_r   <= mag(B, Signed);
            qneg_r  <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_r  <= Signed & A[WIDTH-1];
            ov_r    <= Signed && (A == MINV) && (B == ONES);
            dz_r    <= (B == ZERO);
            p_r     <= {(WIDTH+1){1'b0}};
            quot_r  <= ZERO;
            cnt_r   <= {CW{1'b0}};
            Busy    <= 1'b1;
            state_r <= (B == ZERO) ? FIX : CALC;
          end else begin
            Busy    <= 1'b0;
          end
        end
        CALC: begin
          Done   <= 1'b0;
          p_r    <= p_next_s;
          quot_r <= {quot_r[WIDTH-2:0], q_bit_s};
          dvd_r  <= {dvd_r[WIDTH-2:0], 1'b0};
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          if (dz_r) begin
            Q  <= ONES;
            R  <= a_r;
            DZ <= 1'b1;
            V  <= 1'b0;
          end else begin
            Q  <= qneg_r ? neg(quot_r) : quot_r;
            R  <= rneg_r ? neg(p_r[WIDTH-1:0]) : p_r[WIDTH-1:0];
            DZ <= 1'b0;
            V  <= ov_r;
          end
          Done    <= 1'b1;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed testbench for seq_divider_16 with hand-computed expected results.
module tb_seq_divider_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        Signed;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Q;
  logic [15:0] R;
  logic        DZ;
  logic        V;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Q(Q), .R(R), .DZ(DZ), .V(V), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  // Present operands with Start for one accepting edge; returns at the negedge after it.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; Signed = s; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; edges = posedges until Done seen.
  task automatic wait_done(output int edges, output int busy_cycles);
    bit seen;
    seen = 1'b0;
    edges = -1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!seen) begin
        if (Done) begin
          edges = i;
          seen = 1'b1;
        end else begin
          if (Busy) busy_cycles++;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; A = 16'd0; B = 16'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({Q, R, DZ, V, Busy, Done} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got Q=%h R=%h DZ=%b V=%b Busy=%b Done=%b want all 0", Q, R, DZ, V, Busy, Done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", Busy); end
  endtask

  task automatic test_unsigned();
    int e, b;
    issue(16'd100, 16'd7, 1'b0);
    wait_done(e, b);
    checks++;
    if (e !== 17) begin errors++; $display("FAIL u_latency got %0d want 17", e); end
    checks++;
    if (b !== 17) begin errors++; $display("FAIL u_busy_cycles got %0d want 17", b); end
    checks++;
    if ({Q, R, DZ, V} !== {16'd14, 16'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL u_100_7 got Q=%0d R=%0d DZ=%b V=%b want 14 2 0 0", Q, R, DZ, V);
    end
    @(negedge clk);
    checks++;
    if ({Done, Q, R} !== {1'b0, 16'd14, 16'd2}) begin
      errors++; $display("FAIL u_hold got Done=%b Q=%0d R=%0d want 0 14 2", Done, Q, R);
    end
  endtask

  task automatic test_signed();
    int e, b;
    issue(16'hFF9C, 16'd7, 1'b1);
    wait_done(e, b);
    checks++;
    if ({Q, R, DZ, V} !== {16'hFFF2, 16'hFFFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL s_m100_7 got Q=%h R=%h DZ=%b V=%b want fff2 fffe 0 0", Q, R, DZ, V);
    end
    issue(16'd100, 16'hFFF9, 1'b1);
    wait_done(e, b);
    checks++;
    if ({Q, R, DZ, V} !== {16'hFFF2, 16'h0002, 1'b0, 1'b0}) begin
      errors++; $display("FAIL s_100_m7 got Q=%h R=%h DZ=%b V=%b want fff2 0002 0 0", Q, R, DZ, V);
    end
    checks++;
    if (e !== 17) begin errors++; $display("FAIL s_latency got %0d want 17", e); end
  endtask

  task automatic test_boundaries();
    int e, b;
    issue(16'hFFFF, 16'd1, 1'b0);
    wait_done(e, b);
    checks++;
    if ({Q, R, DZ, V} !== {16'hFFFF, 16'h0000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b_ffff_1 got Q=%h R=%h DZ=%b V=%b want ffff 0000 0 0", Q, R, DZ, V);
    end
    issue(16'd5, 16'd9, 1'b0);
    wait_done(e, b);
    checks++;
    if ({Q, R, DZ, V} !== {16'd0, 16'd5, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b_5_9 got Q=%h R=%h DZ=%b V=%b want 0000 0005 0 0", Q, R, DZ, V);
    end
    issue(16'h8000, 16'hFFFF, 1'b1);
    wait_done(e, b);
    checks++;
    if ({Q, R, DZ, V} !== {16'h8000, 16'h0000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b_ovf got Q=%h R=%h DZ=%b V=%b want 8000 0000 0 1", Q, R, DZ, V);
    end
  endtask

  task automatic test_div_zero();
    int e, b;
    issue(16'h1234, 16'h0000, 1'b0);
    wait_done(e, b);
    checks++;
    if (e !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", e); end
    checks++;
    if ({Q, R, DZ, V} !== {16'hFFFF, 16'h1234, 1'b1, 1'b0}) begin
      errors++; $display("FAIL dz_result got Q=%h R=%h DZ=%b V=%b want ffff 1234 1 0", Q, R, DZ, V);
    end
    issue(16'd100, 16'd7, 1'b0);
    wait_done(e, b);
    checks++;
    if ({Q, R, DZ, V} !== {16'd14, 16'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL dz_clear got Q=%0d R=%0d DZ=%b V=%b want 14 2 0 0", Q, R, DZ, V);
    end
  endtask

  task automatic test_ignored_start();
    int e;
    issue(16'd1000, 16'd10, 1'b0);
    e = -1;
    for (int i = 0; i < 40; i++) begin
      if (e < 0) begin
        if (Done) begin
          e = i;
        end else begin
          Start = (i == 3 || i == 10);
          if (Start) begin A = 16'd7; B = 16'd3; Signed = 1'b1; end
          @(negedge clk);
          Start = 1'b0;
        end
      end
    end
    checks++;
    if (e !== 17) begin errors++; $display("FAIL ign_latency got %0d want 17", e); end
    checks++;
    if ({Q, R} !== {16'd100, 16'd0}) begin
      errors++; $display("FAIL ign_result got Q=%0d R=%0d want 100 0", Q, R);
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got Busy=%b want 0", Busy); end
  endtask

  task automatic test_back_to_back();
    int e, b;
    @(negedge clk);
    A = 16'd100; B = 16'd7; Signed = 1'b0; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(e, b);
    checks++;
    if ({Q, R} !== {16'd14, 16'd2}) begin
      errors++; $display("FAIL b2b_first got Q=%0d R=%0d want 14 2", Q, R);
    end
    // Start is still high while Done is high, so this edge accepts the next operation.
    A = 16'hFFFF; B = 16'd1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", Busy); end
    wait_done(e, b);
    checks++;
    if (e !== 17) begin errors++; $display("FAIL b2b_latency got %0d want 17", e); end
    checks++;
    if ({Q, R} !== {16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL b2b_second got Q=%h R=%h want ffff 0000", Q, R);
    end
  endtask

  task automatic test_reset_mid();
    int e, b;
    issue(16'd100, 16'd7, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Q, R, DZ, V, Busy, Done} !== 36'd0) begin
      errors++;
      $display("FAIL rst_mid got Q=%h R=%h DZ=%b V=%b Busy=%b Done=%b want all 0", Q, R, DZ, V, Busy, Done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL rst_held got Busy=%b Done=%b want 0 0", Busy, Done); end
    rst_n = 1'b1;
    issue(16'd100, 16'd7, 1'b0);
    wait_done(e, b);
    checks++;
    if ({Q, R, DZ, V} !== {16'd14, 16'd2, 1'b0, 1'b0} || e !== 17) begin
      errors++; $display("FAIL rst_recover got Q=%0d R=%0d DZ=%b V=%b edges=%0d want 14 2 0 0 17", Q, R, DZ, V, e);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_boundaries();
    test_div_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
